// File: rtl/rx_message_reg_if.sv
// Bus bundle between the UART receive path, the message queue and the game logic.
// Handshake: a byte is offered by holding rx_valid high for one clk cycle
// (rx_err qualifies it). The head byte is taken on a posedge where msg_valid
// and msg_ack are both high. msg_ack while msg_valid is low has no effect.
interface rx_message_reg_if #(
    parameter int DEPTH = 4
) ();
    localparam int CW = $clog2(DEPTH) + 1;

    logic [7:0]    rx_byte;
    logic          rx_valid;
    logic          rx_err;
    logic          msg_ack;
    logic          clr_err;
    logic [7:0]    msg;
    logic          msg_valid;
    logic [CW-1:0] count;
    logic          green;
    logic          red;
    logic          overflow;

    // Producer/consumer side (receiver + game logic, or a testbench).
    modport master (
        output rx_byte, rx_valid, rx_err, msg_ack, clr_err,
        input  msg, msg_valid, count, green, red, overflow
    );

    // Queue side.
    modport slave (
        input  rx_byte, rx_valid, rx_err, msg_ack, clr_err,
        output msg, msg_valid, count, green, red, overflow
    );
endinterface

// File: rtl/rx_message_reg.sv
// Receive message queue: circular FIFO of UART bytes with a registered head,
// activity LED stretcher and sticky error/overflow flags.
// Optional build macro RX_IDLE_FILTER_EN: drops error-free 8'hFF idle bytes.
module rx_message_reg #(
    parameter int DEPTH        = 4,
    parameter int GREEN_CYCLES = 255
) (
    input  logic            clk,
    input  logic            nRst,
    rx_message_reg_if.slave bus,
    output logic            dbg_state_o
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] FULL_CNT   = CW'(DEPTH);
    localparam logic [CW-1:0] ONE_CNT    = CW'(1);
    localparam logic [7:0]    GREEN_LOAD = 8'(GREEN_CYCLES);

    typedef enum logic {EMPTY = 1'b0, HOLD = 1'b1} state_t;

    state_t        state_q, state_d;
    logic [7:0]    mem_q [DEPTH];
    logic [PW-1:0] rd_ptr_q, wr_ptr_q, rd_ptr_nxt;
    logic [CW-1:0] count_q, count_d;
    logic [7:0]    msg_q, msg_d;
    logic [7:0]    stretch_q, stretch_d;
    logic          red_q, red_d;
    logic          ovf_q, ovf_d;
    logic          idle_byte, data_ok, full, push, pop;

`ifdef RX_IDLE_FILTER_EN
    assign idle_byte = (bus.rx_byte == 8'hFF);
`else
    assign idle_byte = 1'b0;
`endif

    assign full       = (count_q == FULL_CNT);
    assign pop        = (state_q == HOLD) && bus.msg_ack;
    assign data_ok    = bus.rx_valid && !bus.rx_err && !idle_byte;
    // A full queue still accepts a byte when the head leaves in the same cycle.
    assign push       = data_ok && (!full || pop);
    assign rd_ptr_nxt = rd_ptr_q + 1'b1;

    // Next state of the output FSM and the registered head byte.
    always_comb begin
        state_d = state_q;
        msg_d   = msg_q;
        case (state_q)
            EMPTY: if (push) state_d = HOLD;
            HOLD:  if (pop && count_q == ONE_CNT && !push) state_d = EMPTY;
            default: state_d = EMPTY;
        endcase
        if (pop) begin
            if (count_q == ONE_CNT) begin
                if (push) msg_d = bus.rx_byte;
            end else begin
                msg_d = mem_q[rd_ptr_nxt];
            end
        end else if (push && count_q == '0) begin
            msg_d = bus.rx_byte;
        end
    end

    // Occupancy, LED stretcher and sticky flags.
    always_comb begin
        count_d = count_q;
        case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
        stretch_d = stretch_q;
        if (push)                  stretch_d = GREEN_LOAD;
        else if (stretch_q != '0)  stretch_d = stretch_q - 1'b1;
        // A set condition wins over a coincident clear.
        red_d = (bus.rx_valid && bus.rx_err) || (red_q && !bus.clr_err);
        ovf_d = (data_ok && full && !pop) || (ovf_q && !bus.clr_err);
    end

    // Control state with asynchronous active-low reset.
    always_ff @(posedge clk or negedge nRst) begin
        if (!nRst) begin
            state_q   <= EMPTY;
            rd_ptr_q  <= '0;
            wr_ptr_q  <= '0;
            count_q   <= '0;
            msg_q     <= 8'h00;
            stretch_q <= '0;
            red_q     <= 1'b0;
            ovf_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            count_q   <= count_d;
            msg_q     <= msg_d;
            stretch_q <= stretch_d;
            red_q     <= red_d;
            ovf_q     <= ovf_d;
            if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_q <= rd_ptr_nxt;
        end
    end

    // Storage is only ever written by a push; no reset needed for data.
    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= bus.rx_byte;
    end

    assign bus.msg       = msg_q;
    assign bus.msg_valid = (state_q == HOLD);
    assign bus.count     = count_q;
    assign bus.green     = (stretch_q != '0);
    assign bus.red       = red_q;
    assign bus.overflow  = ovf_q;
    assign dbg_state_o   = state_q;
endmodule

// File: tb/tb_rx_message_reg.sv
// Directed bench for rx_message_reg (DEPTH=4, GREEN_CYCLES=5).
// Popped head bytes are checked against an expected queue by a monitor.
module tb_rx_message_reg;
    localparam int DEPTH = 4;
    localparam int GC    = 5;

    logic clk = 1'b0;
    logic nRst = 1'b0;
    logic dbg_state;
    int   total = 0;
    int   bad   = 0;
    logic [7:0] exp_q[$];

    rx_message_reg_if #(.DEPTH(DEPTH)) bus ();

    rx_message_reg #(.DEPTH(DEPTH), .GREEN_CYCLES(GC)) dut (
        .clk         (clk),
        .nRst        (nRst),
        .bus         (bus.slave),
        .dbg_state_o (dbg_state)
    );

    // clock / reset
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL timeout total=%0d bad=%0d", total, bad);
        $fatal(1, "timeout");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Advance one edge; inputs change and outputs are sampled 1 time unit later.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.rx_byte  = 8'h00;
        bus.rx_valid = 1'b0;
        bus.rx_err   = 1'b0;
        bus.msg_ack  = 1'b0;
        bus.clr_err  = 1'b0;
    endtask

    task automatic send(input logic [7:0] b);
        bus.rx_byte  = b;
        bus.rx_valid = 1'b1;
        tick();
        bus.rx_valid = 1'b0;
    endtask

    task automatic ack_n(input int n);
        bus.msg_ack = 1'b1;
        repeat (n) tick();
        bus.msg_ack = 1'b0;
    endtask

    // Monitor: a pop happens at the coming posedge; compare the head byte.
    always @(negedge clk) begin
        if (nRst && bus.msg_valid && bus.msg_ack) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL pop_unexpected: got %0h expected none", bus.msg);
            end else begin
                check("pop_order", {24'h0, bus.msg}, {24'h0, exp_q.pop_front()});
            end
        end
    end

    initial begin
        idle_inputs();
        // reset state
        nRst = 1'b0;
        #12;
        check("rst_msg", bus.msg, 8'h00);
        check("rst_valid", bus.msg_valid, 1'b0);
        check("rst_count", bus.count, 0);
        check("rst_green", bus.green, 1'b0);
        check("rst_red", bus.red, 1'b0);
        check("rst_ovf", bus.overflow, 1'b0);
        @(negedge clk);
        nRst = 1'b1;
        tick();

        // single byte, one-edge latency, green stretch
        exp_q.push_back(8'h41);
        send(8'h41);
        check("b41_msg", bus.msg, 8'h41);
        check("b41_valid", bus.msg_valid, 1'b1);
        check("b41_count", bus.count, 1);
        check("b41_green", bus.green, 1'b1);
        check("b41_state", dbg_state, 1'b1);
        ack_n(1);
        check("b41_valid_after", bus.msg_valid, 1'b0);
        check("b41_count_after", bus.count, 0);
        repeat (3) tick();
        check("green_last", bus.green, 1'b1);
        tick();
        check("green_off", bus.green, 1'b0);

        // ack while empty is ignored
        ack_n(1);
        check("ack_empty_count", bus.count, 0);
        check("ack_empty_valid", bus.msg_valid, 1'b0);

        // overflow on fifth byte
        for (int i = 1; i <= 4; i++) exp_q.push_back(8'(i));
        for (int i = 1; i <= 5; i++) send(8'(i));
        check("ovf_count", bus.count, 4);
        check("ovf_flag", bus.overflow, 1'b1);
        check("ovf_head", bus.msg, 8'h01);
        ack_n(4);
        check("ovf_drained", bus.count, 0);
        check("ovf_sticky", bus.overflow, 1'b1);
        bus.clr_err = 1'b1;
        tick();
        bus.clr_err = 1'b0;
        check("ovf_clr", bus.overflow, 1'b0);

        // push + pop while full
        exp_q.push_back(8'h11);
        exp_q.push_back(8'h22);
        exp_q.push_back(8'h33);
        exp_q.push_back(8'h44);
        send(8'h11); send(8'h22); send(8'h33); send(8'h44);
        exp_q.push_back(8'h55);
        bus.msg_ack = 1'b1;
        send(8'h55);
        bus.msg_ack = 1'b0;
        check("full_pp_count", bus.count, 4);
        check("full_pp_ovf", bus.overflow, 1'b0);
        check("full_pp_head", bus.msg, 8'h22);
        // overflow set coinciding with clr_err stays set
        bus.clr_err = 1'b1;
        send(8'h66);
        check("ovf_set_clr", bus.overflow, 1'b1);
        check("ovf_set_clr_cnt", bus.count, 4);
        tick();
        bus.clr_err = 1'b0;
        check("ovf_clr2", bus.overflow, 1'b0);
        ack_n(4);
        check("full_drained", bus.count, 0);

        // error byte
        bus.rx_err = 1'b1;
        send(8'h33);
        bus.rx_err = 1'b0;
        check("err_count", bus.count, 0);
        check("err_red", bus.red, 1'b1);
        check("err_valid", bus.msg_valid, 1'b0);
        tick();
        check("red_sticky", bus.red, 1'b1);
        bus.clr_err = 1'b1;
        tick();
        bus.clr_err = 1'b0;
        check("red_clr", bus.red, 1'b0);

        // push + pop with count=1: pushed byte becomes head
        exp_q.push_back(8'h81);
        exp_q.push_back(8'h82);
        send(8'h81);
        bus.msg_ack = 1'b1;
        send(8'h82);
        bus.msg_ack = 1'b0;
        check("pp1_head", bus.msg, 8'h82);
        check("pp1_count", bus.count, 1);
        check("pp1_valid", bus.msg_valid, 1'b1);
        ack_n(1);
        check("pp1_empty", bus.msg_valid, 1'b0);

        // idle pattern 8'hFF
        repeat (GC + 1) tick();
        check("pre_ff_green", bus.green, 1'b0);
`ifdef RX_IDLE_FILTER_EN
        send(8'hFF);
        check("ff_count", bus.count, 0);
        check("ff_green", bus.green, 1'b0);
        check("ff_valid", bus.msg_valid, 1'b0);
`else
        exp_q.push_back(8'hFF);
        send(8'hFF);
        check("ff_count", bus.count, 1);
        check("ff_msg", bus.msg, 8'hFF);
        check("ff_green", bus.green, 1'b1);
        ack_n(1);
`endif

        // reset mid-operation discards queue
        send(8'hA1); send(8'hA2); send(8'hA3);
        check("mid_count", bus.count, 3);
        #3;
        nRst = 1'b0;
        #1;
        check("mr_count", bus.count, 0);
        check("mr_valid", bus.msg_valid, 1'b0);
        check("mr_msg", bus.msg, 8'h00);
        check("mr_green", bus.green, 1'b0);
        @(negedge clk);
        nRst = 1'b1;
        tick();
        exp_q.push_back(8'h7A);
        send(8'h7A);
        check("pr_msg", bus.msg, 8'h7A);
        check("pr_valid", bus.msg_valid, 1'b1);
        check("pr_count", bus.count, 1);
        ack_n(1);
        tick();

        check("exp_q_empty", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/rx_message_reg.md
RX_MESSAGE_REG -- requirements
Module: rx_message_reg

Interface
REQ-001 Parameter: DEPTH, 4, FIFO entries; power of two, 2..16.
REQ-002 Parameter: GREEN_CYCLES, 255, green LED stretch length in clk cycles, 1..255.
REQ-003 Port: clk  input  1  system clock; all state updates on posedge.
REQ-004 Port: nRst  input  1  asynchronous active-low reset.
REQ-005 Port: rx_byte  input  8  byte from UART receiver; valid only with rx_valid.
REQ-006 Port: rx_valid  input  1  single-cycle strobe, received byte present.
REQ-007 Port: rx_err  input  1  framing/stop-bit error, qualified by rx_valid.
REQ-008 Port: msg_ack  input  1  consumer (game logic) takes head byte.
REQ-009 Port: clr_err  input  1  clears sticky error flags.
REQ-010 Port: msg  output  8  head-of-queue byte, registered.
REQ-011 Port: msg_valid  output  1  msg holds an unconsumed byte.
REQ-012 Port: count  output  $clog2(DEPTH)+1  bytes currently queued.
REQ-013 Port: green  output  1  receive-activity LED.
REQ-014 Port: red  output  1  sticky receive-error LED.
REQ-015 Port: overflow  output  1  sticky, byte lost because queue full.

Function
REQ-016 Queue SHALL be a DEPTH-entry circular FIFO; read/write pointers wrap modulo DEPTH.
REQ-017 Push SHALL occur on a posedge with rx_valid=1, rx_err=0, and (count<DEPTH or pop in same cycle).
REQ-018 Pop SHALL occur on a posedge with msg_valid=1 and msg_ack=1; msg_ack with msg_valid=0 SHALL be ignored.
REQ-019 Output FSM SHALL have states EMPTY and HOLD; EMPTY->HOLD on push; HOLD->EMPTY on pop with count=1 and no push; otherwise hold.
REQ-020 msg_valid SHALL equal (state==HOLD); msg SHALL equal the FIFO head entry.
REQ-021 Latency: byte pushed into empty queue at edge N SHALL appear on msg with msg_valid=1 after edge N.
REQ-022 Simultaneous push and pop SHALL leave count unchanged, with byte order preserved; when count=1 the pushed byte becomes head.
REQ-023 Simultaneous push and pop when full SHALL be accepted, with no overflow.
REQ-024 rx_valid with count=DEPTH and no pop SHALL drop the byte and set overflow.
REQ-025 rx_valid with rx_err=1 SHALL drop the byte and set red; count unchanged.
REQ-026 overflow and red SHALL stay set until a posedge with clr_err=1; if a set condition coincides with clr_err, the flag SHALL remain set.
REQ-027 count SHALL increment on push-only, decrement on pop-only, never exceed DEPTH or go below 0.
REQ-028 green SHALL assert the cycle after each push and stay high GREEN_CYCLES cycles; a new push reloads the stretch counter.
REQ-029 FIFO storage contents SHALL not be modified except by push.

Reset
REQ-030 nRst low SHALL asynchronously force: state=EMPTY, pointers=0, count=0, msg=8'h00, msg_valid=0, green=0, red=0, overflow=0, stretch counter=0.
REQ-031 Reset mid-operation SHALL discard all queued bytes; the first post-reset push SHALL be treated as into an empty queue.

Configuration
REQ-032 Macro RX_IDLE_FILTER_EN: when defined, an error-free rx_valid with rx_byte=8'hFF (transmitter idle pattern) SHALL be discarded (no push, no green, no flag).
REQ-033 When RX_IDLE_FILTER_EN is undefined, 8'hFF SHALL be handled as an ordinary data byte.

Verification
REQ-034 Reset, then push 8'h41 -> after the next edge msg=8'h41, msg_valid=1, count=1, green=1; msg_ack one cycle -> msg_valid=0, count=0.
REQ-035 Push 8'h01..8'h05 with DEPTH=4 and no ack -> count=4, overflow=1; acks yield 01,02,03,04 in order; clr_err -> overflow=0.
REQ-036 Queue full, push 8'h55 with msg_ack in the same cycle -> count stays 4, overflow=0, 8'h55 is last out.
REQ-037 rx_valid with rx_err=1, rx_byte=8'h33 -> count unchanged, red=1; clr_err pulse -> red=0.
REQ-038 Push 8'hFF -> queued when RX_IDLE_FILTER_EN is undefined; count stays 0 and green stays 0 when it is defined.
REQ-039 nRst pulsed low with 3 bytes queued, mid-cycle -> outputs zero immediately; next push 8'h7A appears as head after one edge.
